// File: rtl/qconv_states_if.sv
// qconv_states_if: control/status bundle for the qconv_states sequencer.
//   start   - run request, driven by the requester (master)
//   finish  - one-cycle completion pulse from the sequencer (slave)
//   busy    - sequencer is in any state other than IDLE
//   state   - current state encoding (IDLE=0, LOAD_K=1, CONV=2, STORE=3, DONE=4)
//   oc_high - index of the output-channel tile being processed
interface qconv_states_if #(
    parameter int OcHighBitWidth = 4
);
    logic                      start;
    logic                      finish;
    logic                      busy;
    logic [2:0]                state;
    logic [OcHighBitWidth-1:0] oc_high;

    modport master (
        output start,
        input  finish, busy, state, oc_high
    );

    modport slave (
        input  start,
        output finish, busy, state, oc_high
    );
endinterface

// File: rtl/qconv_states.sv
// qconv_states: run sequencer for a tiled quantised convolution.
// A run walks OcHighNum output-channel tiles; each tile spends KLoadCycles in
// LOAD_K, ConvCycles in CONV and StoreCycles in STORE, then the run ends with
// a single DONE cycle that raises finish.
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - asynchronous reset, active HIGH (name kept for compatibility)
//   ctrl  - qconv_states_if slave: start in; finish, busy, state, oc_high out
module qconv_states #(
    parameter int OcHighBitWidth = 4,
    parameter int OcHighNum      = 3,
    parameter int KLoadCycles    = 4,
    parameter int ConvCycles     = 8,
    parameter int StoreCycles    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    qconv_states_if.slave ctrl
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_K = 3'd1,
        CONV   = 3'd2,
        STORE  = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Terminal phase counts; a phase of N cycles ends when the counter reads N-1.
    localparam logic [7:0] KLast     = 8'(KLoadCycles - 1);
    localparam logic [7:0] ConvLast  = 8'(ConvCycles - 1);
    localparam logic [7:0] StoreLast = 8'(StoreCycles - 1);
    localparam logic [OcHighBitWidth-1:0] OcLast = OcHighBitWidth'(OcHighNum - 1);

    state_e                    state_q, state_d;
    logic [7:0]                phase_q, phase_d;
    logic [OcHighBitWidth-1:0] oc_q,    oc_d;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            oc_q    <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            oc_q    <= oc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 8'd1;
        oc_d    = oc_q;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (ctrl.start) begin
                    state_d = LOAD_K;
                    oc_d    = '0;
                end
            end
            LOAD_K: begin
                if (phase_q == KLast) begin
                    state_d = CONV;
                    phase_d = '0;
                end
            end
            CONV: begin
                if (phase_q == ConvLast) begin
                    state_d = STORE;
                    phase_d = '0;
                end
            end
            STORE: begin
                if (phase_q == StoreLast) begin
                    phase_d = '0;
                    if (oc_q == OcLast) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD_K;
                        oc_d    = oc_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // oc_high keeps the last tile index until the next accepted start.
                state_d = IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Status is decoded from registered state only, so start never reaches finish.
    always_comb begin
        ctrl.state   = state_q;
        ctrl.finish  = (state_q == DONE);
        ctrl.busy    = (state_q != IDLE);
        ctrl.oc_high = oc_q;
    end

endmodule

// File: tb/tb_qconv_states.sv
module tb_qconv_states;
    localparam int W = 4;
    localparam int N = 3;
    localparam int K = 4;
    localparam int C = 8;
    localparam int S = 2;
    localparam int T = K + C + S;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    qconv_states_if #(.OcHighBitWidth(W)) bus_a ();
    qconv_states_if #(.OcHighBitWidth(W)) bus_b ();

    qconv_states #(
        .OcHighBitWidth(W), .OcHighNum(N), .KLoadCycles(K),
        .ConvCycles(C), .StoreCycles(S)
    ) dut_a (.clk(clk), .rst_n(rst_n), .ctrl(bus_a));

    qconv_states #(
        .OcHighBitWidth(W), .OcHighNum(1), .KLoadCycles(1),
        .ConvCycles(1), .StoreCycles(1)
    ) dut_b (.clk(clk), .rst_n(rst_n), .ctrl(bus_b));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: a run is described by the elapsed cycles since the
    // accepting edge; state and tile follow from plain division.
    bit m_run  = 0;
    bit m_done = 0;
    int m_t    = 0;
    int m_oc   = 0;

    function automatic int m_state();
        int w;
        if (m_done) return 4;
        if (!m_run) return 0;
        w = m_t % T;
        if (w < K) return 1;
        if (w < K + C) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_t = 0; m_oc = 0;
    endtask

    task automatic model_step(input bit r, input bit s);
        if (r) model_reset();
        else if (m_run) begin
            m_t++;
            if (m_t == N * T) begin
                m_run  = 0;
                m_done = 1;
            end else begin
                m_oc = m_t / T;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (s) begin
            m_run = 1; m_t = 0; m_oc = 0;
        end
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_a();
        cmp("model.state",   int'(bus_a.state),   m_state());
        cmp("model.oc_high", int'(bus_a.oc_high), m_oc);
        cmp("model.finish",  int'(bus_a.finish),  int'(m_state() == 4));
        cmp("model.busy",    int'(bus_a.busy),    int'(m_state() != 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst_n, bus_a.start);
        #1;
        cyc++;
        check_a();
    endtask

    task automatic go_idle();
        bus_a.start = 1'b0;
        for (int i = 0; i < 60 && bus_a.state != 3'd0; i++) tick();
        cmp("go_idle", int'(bus_a.state), 0);
    endtask

    // Waits (bounded) for finish on dut_a; returns cycles since c0, or -1.
    task automatic wait_finish_a(input int c0, output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus_a.finish) begin
                lat = cyc - c0;
                break;
            end
            tick();
        end
    endtask

    typedef struct {
        bit rst;
        bit start;
        int ncyc;
        int st;
        int oc;
        bit fin;
        bit busy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int c0;
        int lat;
        int nfin;
        int fin_cyc[$];

        bus_a.start = 1'b0;
        bus_b.start = 1'b0;

        // Directed table: reset, idle wait, one full default run, back-to-back start.
        tbl[0]  = '{1, 0,  2, 0, 0, 0, 0};
        tbl[1]  = '{0, 0,  8, 0, 0, 0, 0};
        tbl[2]  = '{0, 1,  1, 1, 0, 0, 1};
        tbl[3]  = '{0, 0,  3, 1, 0, 0, 1};
        tbl[4]  = '{0, 0,  1, 2, 0, 0, 1};
        tbl[5]  = '{0, 0,  8, 3, 0, 0, 1};
        tbl[6]  = '{0, 0,  2, 1, 1, 0, 1};
        tbl[7]  = '{0, 0, 14, 1, 2, 0, 1};
        tbl[8]  = '{0, 0, 13, 3, 2, 0, 1};
        tbl[9]  = '{0, 0,  1, 4, 2, 1, 1};
        tbl[10] = '{0, 0,  1, 0, 2, 0, 0};
        tbl[11] = '{0, 1,  1, 1, 0, 0, 1};

        for (int v = 0; v < 12; v++) begin
            rst_n       = tbl[v].rst;
            bus_a.start = tbl[v].start;
            for (int n = 0; n < tbl[v].ncyc; n++) begin
                tick();
                if (tbl[v].rst) begin
                    cmp("tbl.rst_state", int'(bus_a.state), 0);
                    cmp("tbl.rst_busy",  int'(bus_a.busy), 0);
                end
            end
            cmp($sformatf("tbl[%0d].state", v),   int'(bus_a.state),   tbl[v].st);
            cmp($sformatf("tbl[%0d].oc_high", v), int'(bus_a.oc_high), tbl[v].oc);
            cmp($sformatf("tbl[%0d].finish", v),  int'(bus_a.finish),  int'(tbl[v].fin));
            cmp($sformatf("tbl[%0d].busy", v),    int'(bus_a.busy),    int'(tbl[v].busy));
        end
        go_idle();

        // Latency of a single start pulse.
        bus_a.start = 1'b1;
        tick();
        c0 = cyc;
        bus_a.start = 1'b0;
        wait_finish_a(c0, lat);
        cmp("latency_default", lat, 42);
        tick();
        cmp("finish_one_cycle", int'(bus_a.finish), 0);
        go_idle();

        // start held high: back-to-back runs 44 cycles apart.
        bus_a.start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus_a.finish) fin_cyc.push_back(cyc);
        end
        cmp("held_start_runs", int'(fin_cyc.size() >= 2), 1);
        if (fin_cyc.size() >= 2) cmp("held_start_spacing", fin_cyc[1] - fin_cyc[0], 44);
        go_idle();

        // start pulses in LOAD_K, CONV, STORE and DONE are ignored.
        bus_a.start = 1'b1;
        tick();
        nfin = 0;
        for (int i = 1; i <= 48; i++) begin
            bus_a.start = (i <= 43) && ((i % 4 == 0) || (bus_a.state == 3'd4));
            tick();
            if (bus_a.finish) nfin++;
        end
        cmp("ignored_starts_finish_count", nfin, 1);
        cmp("ignored_starts_idle", int'(bus_a.state), 0);
        go_idle();

        // Async reset during CONV of tile 1 aborts the run.
        bus_a.start = 1'b1;
        tick();
        c0 = cyc;
        bus_a.start = 1'b0;
        repeat (T + K + 2) tick();
        cmp("abort.pre_state", int'(bus_a.state), 2);
        cmp("abort.pre_oc", int'(bus_a.oc_high), 1);
        #3;
        rst_n = 1'b1;
        bus_a.start = 1'b1;
        #1;
        model_reset();
        cmp("abort.async_state", int'(bus_a.state), 0);
        cmp("abort.async_oc", int'(bus_a.oc_high), 0);
        cmp("abort.async_busy", int'(bus_a.busy), 0);
        tick();
        rst_n = 1'b0;
        bus_a.start = 1'b0;
        nfin = 0;
        repeat (5) begin
            tick();
            if (bus_a.finish) nfin++;
        end
        cmp("abort.no_finish", nfin, 0);
        cmp("abort.waits_idle", int'(bus_a.state), 0);
        bus_a.start = 1'b1;
        tick();
        c0 = cyc;
        bus_a.start = 1'b0;
        wait_finish_a(c0, lat);
        cmp("abort.restart_latency", lat, 42);
        go_idle();

        // Minimal configuration instance.
        bus_b.start = 1'b1;
        tick();
        c0 = cyc;
        bus_b.start = 1'b0;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            cmp("min.oc_high", int'(bus_b.oc_high), 0);
            if (bus_b.finish) begin
                lat = cyc - c0;
                break;
            end
            tick();
        end
        cmp("min.latency", lat, 3);
        tick();
        cmp("min.idle", int'(bus_b.state), 0);

        // Random start and occasional reset against the model.
        for (int i = 0; i < 1500; i++) begin
            bus_a.start = ($urandom_range(0, 3) == 0);
            rst_n       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst_n = 1'b0;
        go_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/qconv_states.md
QCONV_STATES -- requirements
Module: qconv_states

Interface
REQ-001 Parameter OcHighBitWidth, default 4: width of the output-channel-tile (oc_high) counter.
REQ-002 Parameter OcHighNum, default 3: number of output-channel tiles per run; legal range 1..2**OcHighBitWidth.
REQ-003 Parameter KLoadCycles, default 4: cycles spent in LOAD_K per tile; legal range 1..256.
REQ-004 Parameter ConvCycles, default 8: cycles spent in CONV per tile; legal range 1..256.
REQ-005 Parameter StoreCycles, default 2: cycles spent in STORE per tile; legal range 1..256.
REQ-006 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous active-high reset (asserted when 1); port name kept for codebase compatibility.
REQ-009 start  input  1  run request, sampled on rising clk only in IDLE.
REQ-010 finish  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 state  output  3  current state encoding: IDLE=0, LOAD_K=1, CONV=2, STORE=3, DONE=4.
REQ-013 oc_high  output  OcHighBitWidth  index of the tile being processed.

Function
REQ-014 FSM states SHALL be IDLE, LOAD_K, CONV, STORE, DONE; encodings 5-7 unreachable and SHALL return to IDLE on the next edge.
REQ-015 IDLE: start=1 at a rising edge -> LOAD_K, phase counter cleared, oc_high cleared to 0; start=0 -> stay IDLE.
REQ-016 An 8-bit phase counter SHALL count cycles within LOAD_K, CONV, STORE and be cleared on every state change.
REQ-017 LOAD_K SHALL last exactly KLoadCycles cycles, then go to CONV.
REQ-018 CONV SHALL last exactly ConvCycles cycles, then go to STORE.
REQ-019 STORE SHALL last exactly StoreCycles cycles; then if oc_high == OcHighNum-1 go to DONE, else increment oc_high and go to LOAD_K.
REQ-020 DONE SHALL last exactly one cycle, then go to IDLE; oc_high SHALL hold its final value until the next start.
REQ-021 finish SHALL be 1 exactly while state==DONE, decoded from registered state (no combinational path from start).
REQ-022 start SHALL be ignored in every state other than IDLE, including DONE; no queuing of requests.
REQ-023 Latency: with start sampled at edge E0, finish SHALL be high in the cycle following edge E0 + OcHighNum*(KLoadCycles+ConvCycles+StoreCycles); default 42 cycles.
REQ-024 Back-to-back: start high in the first IDLE cycle after DONE SHALL begin a new run on that edge.
REQ-025 oc_high SHALL never exceed OcHighNum-1 and SHALL not wrap.

Reset
REQ-026 rst_n=1 SHALL asynchronously force state=IDLE, oc_high=0, phase counter=0, finish=0, busy=0, regardless of clk.
REQ-027 Reset asserted mid-run SHALL abort the run with no finish pulse; after release, the FSM SHALL wait in IDLE for a new start.
REQ-028 start asserted while rst_n=1 SHALL have no effect.

Verification
REQ-029 Reset held 2 cycles, start=0 -> state=0, busy=0, finish=0, oc_high=0 throughout.
REQ-030 Defaults, single-cycle start pulse after 8 idle cycles -> finish high exactly 1 cycle, 42 cycles after start edge; oc_high steps 0,1,2 at cycles 0,14,28; then IDLE.
REQ-031 start held high for 100 cycles -> runs repeat back-to-back with finish pulses 44 cycles apart (42 working + DONE + IDLE).
REQ-032 start pulses during LOAD_K, CONV, STORE, DONE -> ignored; exactly one finish per accepted start.
REQ-033 Reset asserted during CONV of tile 1 -> immediate IDLE, oc_high=0, no finish; next start yields finish 42 cycles later.
REQ-034 OcHighNum=1, KLoadCycles=ConvCycles=StoreCycles=1 -> finish 3 cycles after start edge; oc_high stays 0.
